// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams a length-prefixed image into IMEM.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t state, nxt;

    logic [7:0]    len_hi;
    logic [15:0]   len;
    logic [IW-1:0] idx;
    logic          fire;
    logic          last;
    logic [15:0]   len_full;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign fire     = in_valid & in_ready;
    assign len_full = {len_hi, in_data};
    // idx is one bit wider than the address so a full-depth image ends cleanly
    assign last     = (32'(idx) + 32'd1) == 32'(len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: nxt = LEN_HI;
            LEN_HI: begin
                if (fire) nxt = LEN_LO;
            end
            LEN_LO: begin
                if (fire) begin
                    if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        nxt = CSUM;
`else
                        nxt = DONE;
`endif
                    end else if ({1'b0, len_full} > DEPTH) begin
                        nxt = ERR;
                    end else begin
                        nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (fire && last) begin
`ifdef LOADER_CHECKSUM_EN
                    nxt = CSUM;
`else
                    nxt = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (fire) nxt = (in_data == sum) ? DONE : ERR;
            end
`endif
            DONE: nxt = DONE;
            ERR: nxt = ERR;
            default: nxt = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi <= '0;
            len    <= '0;
            idx    <= '0;
        end else if (fire) begin
            if (state == LEN_HI) len_hi <= in_data;
            if (state == LEN_LO) len <= len_full;
            if (state == DATA) idx <= idx + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (fire && state == DATA) begin
            sum <= sum + in_data;
        end
    end
`endif

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO: in_ready = 1'b1;
            DATA: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = idx[ADDR_WIDTH-1:0];
                mem_wdata = in_valid ? in_data : 8'h00;
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                in_ready = 1'b1;
`endif
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width of instruction memory (depth 2**ADDR_WIDTH bytes).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  8  byte from host stream.
REQ-005 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-007 SHALL have port mem_we  output  1  byte write strobe to instruction memory.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  byte address of write.
REQ-009 SHALL have port mem_wdata  output  8  byte written.
REQ-010 SHALL have port cpu_hold  output  1  holds processor in reset while high.
REQ-011 SHALL have port done  output  1  load completed successfully (sticky).
REQ-012 SHALL have port error  output  1  load failed (sticky).

Function
REQ-013 Byte transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR; IDLE transitions to LEN_HI on the first cycle after reset deasserts.
REQ-015 LEN_HI/LEN_LO SHALL capture a 16-bit big-endian byte count N, one accepted byte each.
REQ-016 After LEN_LO: N=0 -> DONE (or CSUM when checksum enabled); N > 2**ADDR_WIDTH -> ERR; else -> DATA.
REQ-017 In DATA each accepted byte SHALL produce mem_we=1 in the same cycle with mem_addr = byte index (0,1,2,...) and mem_wdata = in_data; zero added latency.
REQ-018 Byte index SHALL be ADDR_WIDTH+1 bits wide internally so N = 2**ADDR_WIDTH completes without wrap; mem_addr carries the low ADDR_WIDTH bits.
REQ-019 After the N-th data byte DATA SHALL exit to CSUM (checksum enabled) or DONE.
REQ-020 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, DONE, ERR.
REQ-021 mem_we SHALL be 0 in every state except DATA with an accepted byte.
REQ-022 cpu_hold SHALL be 1 in all states except DONE.
REQ-023 DONE and ERR SHALL be terminal; further in_valid is not accepted; only reset exits them.
REQ-024 done=1 exactly while in DONE; error=1 exactly while in ERR.
REQ-025 in_valid gaps SHALL stall the FSM with no state or counter change.

Reset
REQ-026 reset=1 SHALL force state IDLE, counters and length to 0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0 on the next rising edge.
REQ-027 reset mid-load SHALL abandon the load; bytes already written remain in memory; a new load begins with a length header.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN SHALL control trailing checksum support.
REQ-029 With LOADER_CHECKSUM_EN defined: 8-bit running sum (mod 256) of all data bytes; one extra byte accepted in CSUM; equal -> DONE, unequal -> ERR.
REQ-030 Without LOADER_CHECKSUM_EN: CSUM state and sum logic absent; DATA (or N=0) goes directly to DONE; no trailing byte consumed.

Verification
REQ-031 Reset then stream 00 04 20 10 00 03 (checksum 0x33 when enabled), in_valid held 1 -> writes addr 0..3 = 20,10,00,03 on consecutive cycles, then done=1, cpu_hold=0.
REQ-032 Same stream with in_valid toggling every other cycle -> identical writes and final state; mem_we only on accepted cycles.
REQ-033 LOADER_CHECKSUM_EN defined, stream 00 02 01 02 04 -> two writes, error=1, done=0, cpu_hold=1.
REQ-034 ADDR_WIDTH=4, length 00 11 (17) -> ERR after LEN_LO, no mem_we ever asserted; length 00 10 -> 16 writes addr 0..15, then done.
REQ-035 reset asserted after 2 of 4 data bytes -> outputs at reset values next edge; a following full load 00 01 FF (+FF checksum) -> addr 0 = FF, done=1.
REQ-036 Length 00 00 (+00 checksum when enabled) -> no writes, done=1.
